mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 one-bit mux between four requesters. Each requester raises a request line. The arbiter grants exactly one requester at a time and drives the mux selects `s0`/`s1` so that requester's data bit reaches the shared output. It sits directly in front of the existing `mux_4X1` and is the only block allowed to drive its selects.

---
 rtl/arb_pkg.sv | 16 +
 rtl/mux_4X1.sv | 22 ++
 rtl/rr_pick4.sv | 23 ++
 rtl/mux4_rr_arbiter.sv | 79 +++++++
 tb/tb_mux4_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Requester index to mux select {s1,s0}: 0->a, 1->b, 2->c, 3->d.
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/mux_4X1.sv
// Existing shared 4:1 one-bit mux; {s1,s0} selects a/b/c/d.
module mux_4X1 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic s0,
    input  logic s1,
    output logic y
);

    // Plain select decode.
    always_comb begin
        case ({s1, s0})
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      start,
    output logic            valid,
    output logic [1:0]      idx
);

    // Scan offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        valid = 1'b0;
        idx   = start;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[2'(start + 2'(k))]) begin
                valid = 1'b1;
                idx   = 2'(start + 2'(k));
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the selects of the shared 4:1 mux.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       y
);

    arb_state_t       state;
    // ptr is the last granted index; while in GRANT it is also the owner.
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             release_now;
    logic             mux_out;

    // Search always starts just past the last owner, which covers both the
    // idle-entry case and the handoff case (own == ptr while granted).
    rr_pick4 u_pick (
        .req   (req),
        .start (2'(ptr + 2'd1)),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign release_now = !req[ptr] || (cnt == CNT_W'(MAX_HOLD - 1));

    // Single-process FSM with registered grant, selects and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            cnt      <= '0;
            gnt      <= '0;
            {s1, s0} <= 2'b00;
            busy     <= 1'b0;
        end else if (state == GRANT && !release_now) begin
            cnt <= cnt + 1'b1;
        end else if (pick_valid) begin
            // New grant or zero-bubble handoff (possibly back to the same owner).
            state    <= GRANT;
            ptr      <= pick_idx;
            cnt      <= '0;
            gnt      <= 4'b0001 << pick_idx;
            {s1, s0} <= idx_to_sel(pick_idx);
            busy     <= 1'b1;
        end else begin
            // Nobody waiting: go idle, selects and ptr keep their last value.
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end
    end

    mux_4X1 u_mux (
        .a  (din[0]),
        .b  (din[1]),
        .c  (din[2]),
        .d  (din[3]),
        .s0 (s0),
        .s1 (s1),
        .y  (mux_out)
    );

    assign y = busy & mux_out;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter against a cycle-level behavioural model.
module tb_mux4_rr_arbiter;

    localparam int MH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       s0, s1, busy, y;

    int checks;
    int failures;

    // Behavioural model: owner (-1 = idle), cycles held so far, last winner, select value.
    int m_owner;
    int m_held;
    int m_last;
    int m_sel;

    mux4_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
        .gnt  (gnt),
        .s0   (s0),
        .s1   (s1),
        .busy (busy),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic mdl_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_sel   = 0;
    endtask

    // One rising edge of the specified behaviour, from the req seen at that edge.
    task automatic mdl_edge(input logic [3:0] r);
        int w;
        if (m_owner >= 0 && r[m_owner] && m_held < MH) begin
            m_held++;
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_sel   = w;
                m_held  = 1;
            end else begin
                m_owner = -1;
                m_held  = 0;
            end
        end
    endtask

    // Expected {gnt, s1, s0, busy, y} for the current model state and din.
    function automatic logic [7:0] expv();
        logic [3:0] g;
        logic [1:0] sl;
        logic       b, yy;
        g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        sl = m_sel[1:0];
        b  = (m_owner >= 0);
        yy = b && din[m_sel[1:0]];
        return {g, sl, b, yy};
    endfunction

    function automatic logic [7:0] dutv();
        return {gnt, s1, s0, busy, y};
    endfunction

    // Advance one clock, update the model at the edge, return at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) mdl_reset();
        else mdl_edge(req);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        mdl_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b0000;
        din = 4'b0000;
        #1 rst = 1'b1;
        mdl_reset();
        #1;
        checks++;
        if (dutv() !== 8'h00) begin
            failures++;
            $display("FAIL reset_init got=%b want=%b", dutv(), 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        din = 4'b1111;
        for (int n = 0; n < 3; n++) step();
        #2 rst = 1'b1;
        #1;
        mdl_reset();
        checks++;
        if (dutv() !== 8'h00) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", dutv(), 8'h00);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001 || dutv() !== expv()) begin
            failures++;
            $display("FAIL reset_first_grant got=%b want=%b", dutv(), expv());
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        din = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || {s1, s0} !== 2'b10 || y !== 1'b1 || dutv() !== expv()) begin
            failures++;
            $display("FAIL single_grant got=%b want=%b", dutv(), expv());
        end
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || y !== 1'b0 || dutv() !== expv()) begin
            failures++;
            $display("FAIL single_release got=%b want=%b", dutv(), expv());
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        req = 4'b1111;
        din = 4'b0101;
        for (int n = 0; n < 5 * MH; n++) begin
            step();
            want = 4'b0001 << ((n / MH) % 4);
            checks++;
            if (gnt !== want || dutv() !== expv()) begin
                failures++;
                $display("FAIL round_robin cyc=%0d gnt=%b want_gnt=%b got=%b want=%b",
                         n, gnt, want, dutv(), expv());
            end
        end
    endtask

    task automatic test_lone_hog();
        do_reset();
        req = 4'b0010;
        for (int n = 0; n < 20; n++) begin
            din = 4'($urandom);
            step();
            checks++;
            if (gnt !== 4'b0010 || busy !== 1'b1 || dutv() !== expv()) begin
                failures++;
                $display("FAIL lone_hog cyc=%0d got=%b want=%b", n, dutv(), expv());
            end
        end
    endtask

    task automatic test_early_handoff();
        do_reset();
        req = 4'b0010;
        din = 4'b1010;
        for (int n = 0; n < 3; n++) step();
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000 || dutv() !== expv()) begin
            failures++;
            $display("FAIL early_handoff got=%b want=%b", dutv(), expv());
        end
        req = 4'b1001;
        for (int n = 1; n < MH + 3; n++) begin
            step();
            checks++;
            if (gnt !== ((n < MH) ? 4'b1000 : 4'b0001) || dutv() !== expv()) begin
                failures++;
                $display("FAIL handoff_order cyc=%0d got=%b want=%b", n, dutv(), expv());
            end
        end
    endtask

    task automatic test_data_path();
        for (int i = 0; i < 4; i++) begin
            do_reset();
            req = 4'b0001 << i;
            step();
            for (int n = 0; n < 6; n++) begin
                din = 4'($urandom);
                #1;
                checks++;
                if (y !== din[i] || dutv() !== expv()) begin
                    failures++;
                    $display("FAIL data_path own=%0d din=%b y=%b want=%b", i, din, y, din[i]);
                end
            end
        end
        req = 4'b0000;
        step();
        for (int n = 0; n < 4; n++) begin
            din = 4'($urandom);
            #1;
            checks++;
            if (y !== 1'b0 || dutv() !== expv()) begin
                failures++;
                $display("FAIL data_idle din=%b got=%b want=%b", din, dutv(), expv());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din = 4'($urandom);
            step();
            checks++;
            if (dutv() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d req=%b got=%b want=%b", n, req, dutv(), expv());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mdl_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_lone_hog();
        test_early_handoff();
        test_data_path();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
